// File: rtl/rv_instr_encoder.sv
// RV32I LW/SW/ADD encoder and sequential instruction-memory loader; optional feature macro: RV_ENC_ILLEGAL_CHECK_EN.
// Latency: accept at edge N, write presented in cycle N+1; at best one word every 2 cycles.
// Backpressure: req_ready drops for the whole write; wr_en/wr_addr/wr_data are held until wr_ack.
module rv_instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_kind,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [11:0]       req_imm,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    input  logic              wr_ack,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

    state_t            state;
    logic              is_illegal;
    logic [ADDR_W:0]   count_nxt;
    logic [ADDR_W-1:0] ptr;

    function automatic logic [31:0] encode(
        input logic [1:0]  kind,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [11:0] imm
    );
        logic [31:0] w;
        w = 32'h0000_0013;
        case (kind)
            2'b00:   w = {imm, rs1, 3'b010, rd, 7'b0000011};
            2'b01:   w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            2'b10:   w = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
            default: w = 32'h0000_0013;
        endcase
        return w;
    endfunction

    // The pointer never wraps: FULL is entered exactly when it would.
    assign ptr       = count[ADDR_W-1:0];
    assign count_nxt = count + {{ADDR_W{1'b0}}, 1'b1};

`ifdef RV_ENC_ILLEGAL_CHECK_EN
    logic err_q;
    assign is_illegal = (req_kind == 2'b11);
    assign err        = err_q;
`else
    assign is_illegal = 1'b0;
    assign err        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            count     <= '0;
            full      <= 1'b0;
`ifdef RV_ENC_ILLEGAL_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (is_illegal) begin
`ifdef RV_ENC_ILLEGAL_CHECK_EN
                            err_q <= 1'b1;
`endif
                        end else begin
                            state     <= ST_WRITE;
                            req_ready <= 1'b0;
                            wr_en     <= 1'b1;
                            wr_addr   <= ptr;
                            wr_data   <= encode(req_kind, req_rd, req_rs1, req_rs2, req_imm);
                        end
                    end
                end
                ST_WRITE: begin
                    if (wr_ack) begin
                        wr_en <= 1'b0;
                        count <= count_nxt;
                        if (count_nxt == CAPACITY) begin
                            state <= ST_FULL;
                            full  <= 1'b1;
                        end else begin
                            state     <= ST_IDLE;
                            req_ready <= 1'b1;
                        end
                    end
                end
                ST_FULL: begin
                    req_ready <= 1'b0;
                    wr_en     <= 1'b0;
                    full      <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    wr_en     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Bench for rv_instr_encoder (ADDR_W=2): directed test-plan steps followed by randomized rounds.
module tb_rv_instr_encoder;

    localparam int ADDR_W = 2;
    localparam int CAP    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_kind;
    logic [4:0]        req_rd;
    logic [4:0]        req_rs1;
    logic [4:0]        req_rs2;
    logic [11:0]       req_imm;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              wr_ack;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_count;
    logic exp_err;

    rv_instr_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_rd(req_rd), .req_rs1(req_rs1),
        .req_rs2(req_rs2), .req_imm(req_imm),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .count(count), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Reference encoding built from field weights rather than bit concatenation.
    function automatic logic [31:0] ref_enc(input int unsigned k, input int unsigned rd,
                                            input int unsigned rs1, input int unsigned rs2,
                                            input int unsigned imm);
        int unsigned w;
        case (k)
            0:       w = 3 + rd * 128 + 2 * 4096 + rs1 * 32768 + imm * 1048576;
            1:       w = 35 + (imm % 32) * 128 + 2 * 4096 + rs1 * 32768 + rs2 * 1048576
                         + (imm / 32) * 33554432;
            2:       w = 51 + rd * 128 + rs1 * 32768 + rs2 * 1048576;
            default: w = 19;
        endcase
        return w;
    endfunction

    task automatic do_reset();
        rst = 1'b1; req_valid = 1'b0; wr_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_count = 0;
        exp_err   = 1'b0;
    endtask

    // Drives one request at a negedge, holds wr_ack low for dly WRITE cycles, then acks.
    task automatic do_req(input logic [1:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [11:0] imm, input int dly,
                          input logic [31:0] exp_word);
        chk("ready_before_req", req_ready, 1);
        req_valid = 1'b1; req_kind = k; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
        @(negedge clk);
        req_valid = 1'b0;
`ifdef RV_ENC_ILLEGAL_CHECK_EN
        if (k == 2'b11) begin
            exp_err = 1'b1;
            chk("illegal_no_wr_en", wr_en, 0);
            chk("illegal_ready", req_ready, 1);
            chk("illegal_err", err, 1);
            chk("illegal_count", count, exp_count);
            return;
        end
`endif
        chk("wr_en_after_accept", wr_en, 1);
        chk("wr_addr", wr_addr, exp_count % CAP);
        chk("wr_data", wr_data, exp_word);
        chk("ready_in_write", req_ready, 0);
        for (int i = 0; i < dly; i++) begin
            req_valid = 1'($urandom); req_kind = 2'($urandom); req_rd = 5'($urandom);
            req_rs1 = 5'($urandom); req_rs2 = 5'($urandom); req_imm = 12'($urandom);
            @(negedge clk);
            chk("hold_wr_en", wr_en, 1);
            chk("hold_wr_addr", wr_addr, exp_count % CAP);
            chk("hold_wr_data", wr_data, exp_word);
            chk("hold_ready", req_ready, 0);
        end
        req_valid = 1'b0;
        wr_ack = 1'b1;
        @(negedge clk);
        wr_ack = 1'b0;
        exp_count++;
        chk("wr_en_after_ack", wr_en, 0);
        chk("count_after_ack", count, exp_count);
        chk("full_after_ack", full, exp_count == CAP);
        chk("ready_after_ack", req_ready, exp_count != CAP);
        chk("err_after_ack", err, exp_err);
    endtask

    initial begin
        req_kind = 2'b00; req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
        do_reset();
        chk("rst_ready", req_ready, 1);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_err", err, 0);

        // Known encodings; the SW write sits under 5 cycles of backpressure.
        do_req(2'b00, 5'd5, 5'd2, 5'd0, 12'd8, 0, 32'h0081_2283);
        do_req(2'b01, 5'd0, 5'd2, 5'd6, 12'hFFC, 5, 32'hFE61_2E23);
        do_req(2'b10, 5'd1, 5'd2, 5'd3, 12'd0, 0, 32'h0031_00B3);
        chk("count_three", count, 3);
        do_req(2'b10, 5'd7, 5'd8, 5'd9, 12'd0, 0, 32'h0094_03B3);
        chk("full_set", full, 1);

        // Full: further requests and stray acks are ignored.
        req_valid = 1'b1; req_kind = 2'b00; wr_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("full_no_wr_en", wr_en, 0);
            chk("full_no_ready", req_ready, 0);
            chk("full_count", count, CAP);
        end
        req_valid = 1'b0; wr_ack = 1'b0;

        // Reset in the second WRITE cycle together with an ack.
        do_reset();
        req_valid = 1'b1; req_kind = 2'b00; req_rd = 5'd4; req_rs1 = 5'd1; req_imm = 12'd16;
        @(negedge clk);
        req_valid = 1'b0;
        chk("midrst_wr_en_1st", wr_en, 1);
        @(negedge clk);
        rst = 1'b1; wr_ack = 1'b1;
        @(negedge clk);
        rst = 1'b0; wr_ack = 1'b0;
        chk("midrst_wr_en", wr_en, 0);
        chk("midrst_count", count, 0);
        chk("midrst_wr_addr", wr_addr, 0);
        chk("midrst_ready", req_ready, 1);
        do_req(2'b10, 5'd1, 5'd2, 5'd3, 12'd0, 1, 32'h0031_00B3);

        // Reserved kind, then a legal write.
        do_req(2'b11, 5'd3, 5'd3, 5'd3, 12'd3, 0, 32'h0000_0013);
        do_req(2'b00, 5'd5, 5'd2, 5'd0, 12'd8, 2, 32'h0081_2283);
`ifdef RV_ENC_ILLEGAL_CHECK_EN
        chk("err_sticky", err, 1);
        chk("illegal_count_kept", count, 2);
`else
        chk("nop_err_zero", err, 0);
        chk("nop_counted", count, 3);
`endif

        // Randomized rounds against the reference model.
        for (int r = 0; r < 25; r++) begin
            int n;
            do_reset();
            n = int'($urandom_range(1, 6));
            for (int i = 0; i < n && exp_count < CAP; i++) begin
                logic [1:0]  k;
                logic [4:0]  rd, rs1, rs2;
                logic [11:0] imm;
                k = 2'($urandom); rd = 5'($urandom); rs1 = 5'($urandom);
                rs2 = 5'($urandom); imm = 12'($urandom);
                do_req(k, rd, rs1, rs2, imm, int'($urandom_range(0, 3)),
                       ref_enc(k, rd, rs1, rs2, imm));
            end
            chk("rand_count", count, exp_count);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
